// File: rtl/weight_loader.sv
// Weight loader: streams num_rows buffer words to the PE weight shift chain, then pulses w_load.
// Optional `define WL_STALL_CNT_EN adds a saturating stall_cnt output.
`timescale 1ns/1ps
module weight_loader #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 13,
  parameter int ROWS   = 16,
  parameter int CNT_W  = 5
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  num_rows,
  output logic              busy,
  output logic              done,
  output logic              buf_CEN,
  output logic              buf_WEN,
  output logic [ADDR_W-1:0] buf_A,
  output logic              buf_RETN,
  input  logic [DATA_W-1:0] buf_Q,
  output logic [DATA_W-1:0] w_data,
  output logic              w_valid,
  input  logic              w_ready,
  output logic              w_load
`ifdef WL_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_LOAD, S_DONE} state_t;

  localparam logic [CNT_W-1:0] MAX_ROWS = CNT_W'(ROWS);

  state_t            r_state;
  logic [ADDR_W-1:0] r_base;
  logic [CNT_W-1:0]  r_num;
  logic [CNT_W-1:0]  r_issued;
  logic [CNT_W-1:0]  r_accepted;
  logic              r_rd_pend;
  logic              r_skid_valid;
  logic [DATA_W-1:0] r_skid_data;

  logic              w_hs;
  logic              w_out_free;
  logic              w_issue;
  logic [1:0]        w_credit_use;
  logic [CNT_W-1:0]  w_num_clamped;

  assign w_hs          = w_valid & w_ready;
  assign w_out_free    = ~w_valid | w_ready;
  assign w_num_clamped = (num_rows > MAX_ROWS) ? MAX_ROWS : num_rows;

  // Words still held after this cycle's handoff plus the one in flight; a new read
  // may only be issued if the worst case (no handshake next cycle) still fits in 2 slots.
  assign w_credit_use = 2'(r_rd_pend) + 2'(w_valid) + 2'(r_skid_valid) - 2'(w_hs);
  assign w_issue      = (r_state == S_RUN) && (r_issued != r_num) && (w_credit_use < 2'd2);

  assign buf_CEN  = ~w_issue;
  assign buf_WEN  = 1'b1;
  assign buf_RETN = 1'b1;
  assign buf_A    = r_base + ADDR_W'(r_issued);

  // NOTE: every sequential block uses non-blocking assignments so all registers
  // update from the same pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_state    <= S_IDLE;
      r_base     <= '0;
      r_num      <= '0;
      r_issued   <= '0;
      r_accepted <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      w_load     <= 1'b0;
    end else begin
      if (w_issue) r_issued   <= r_issued + 1'b1;
      if (w_hs)    r_accepted <= r_accepted + 1'b1;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_base     <= base_addr;
            r_num      <= w_num_clamped;
            r_issued   <= '0;
            r_accepted <= '0;
            busy       <= 1'b1;
            if (w_num_clamped == '0) begin
              done    <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (r_issued == r_num) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (r_accepted == r_num) begin
            w_load  <= 1'b1;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          w_load  <= 1'b0;
          done    <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Output register plus one skid register; the skid always holds the younger word.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_rd_pend    <= 1'b0;
      r_skid_valid <= 1'b0;
      w_valid      <= 1'b0;
      w_data       <= '0;
    end else begin
      r_rd_pend <= w_issue;
      if (w_out_free) begin
        if (r_skid_valid) begin
          w_valid      <= 1'b1;
          w_data       <= r_skid_data;
          r_skid_valid <= r_rd_pend;
        end else if (r_rd_pend) begin
          w_valid <= 1'b1;
          w_data  <= buf_Q;
        end else begin
          w_valid <= 1'b0;
        end
      end else if (r_rd_pend) begin
        r_skid_valid <= 1'b1;
      end
    end
  end

  // NOTE: pure data register with no reset; r_skid_valid alone qualifies its contents.
  always_ff @(posedge CLK) begin
    if (r_rd_pend && (r_skid_valid || !w_out_free)) r_skid_data <= buf_Q;
  end

`ifdef WL_STALL_CNT_EN
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      stall_cnt <= '0;
    end else if (r_state == S_IDLE && start) begin
      stall_cnt <= '0;
    end else if (busy && w_valid && !w_ready && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_weight_loader.sv
// Scoreboard bench for weight_loader: directed jobs push expected rows, a negedge monitor
// pops and compares every handshake and tracks control-pulse timing.
`timescale 1ns/1ps
module tb_weight_loader;
  localparam int DATA_W = 128;
  localparam int ADDR_W = 13;
  localparam int CNT_W  = 5;

  logic              CLK = 1'b0;
  logic              RSTN = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [CNT_W-1:0]  num_rows = '0;
  logic              busy, done, buf_CEN, buf_WEN, buf_RETN, w_valid, w_load;
  logic [ADDR_W-1:0] buf_A;
  logic [DATA_W-1:0] buf_Q = '0;
  logic [DATA_W-1:0] w_data;
  logic              w_ready = 1'b1;
`ifdef WL_STALL_CNT_EN
  logic [15:0]       stall_cnt;
`endif

  always #5 CLK = ~CLK;

  weight_loader dut (
    .CLK(CLK), .RSTN(RSTN), .start(start), .base_addr(base_addr), .num_rows(num_rows),
    .busy(busy), .done(done), .buf_CEN(buf_CEN), .buf_WEN(buf_WEN), .buf_A(buf_A),
    .buf_RETN(buf_RETN), .buf_Q(buf_Q), .w_data(w_data), .w_valid(w_valid),
    .w_ready(w_ready), .w_load(w_load)
`ifdef WL_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a);
    return {8{{3'b000, a}}};
  endfunction

  // Buffer model: 1-cycle read latency, poison value when not reading.
  always @(posedge CLK) begin
    if (!buf_CEN) buf_Q <= pat(buf_A);
    else          buf_Q <= {16{8'hEE}};
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [DATA_W-1:0] exp_q[$];
  logic [ADDR_W-1:0] addr_log[$];

  int cyc = 0;
  int t0, hs_cnt, load_cnt, done_cnt, cen_cnt, valid_cnt, stall_model, overlap_cnt;
  int reads, max_out, first_valid_cyc, first_hs_cyc, last_hs_cyc, load_cyc, done_cyc;
  logic prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_data;
  bit   pat_en = 1'b0;
  int   pidx = 0;
  logic [5:0] rdy_pat = 6'b101001;  // LSB first: 1,0,0,1,0,1

  always @(posedge CLK) cyc <= cyc + 1;

  always @(posedge CLK) begin
    #2;
    if (pat_en) begin
      w_ready = rdy_pat[pidx];
      pidx = (pidx == 5) ? 0 : pidx + 1;
    end
  end

  always @(negedge CLK) begin
    if (RSTN) begin
      if (!buf_CEN) begin
        reads++;
        cen_cnt++;
        addr_log.push_back(buf_A);
      end
      if (w_valid && w_ready) begin
        hs_cnt++;
        if (first_hs_cyc < 0) first_hs_cyc = cyc;
        last_hs_cyc = cyc;
        if (exp_q.size() == 0) check("extra_beat", exp_q.size(), 1);
        else check("w_data", w_data, exp_q.pop_front());
      end
      if (w_valid) begin
        valid_cnt++;
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
      end
      if (prev_stall) begin
        check("stall_valid_held", w_valid, 1);
        check("stall_data_held", w_data, prev_data);
      end
      prev_stall = w_valid && !w_ready;
      prev_data  = w_data;
      if (busy && w_valid && !w_ready) stall_model++;
      if (w_load) begin
        load_cnt++;
        load_cyc = cyc;
        if (w_valid) overlap_cnt++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (reads - hs_cnt > max_out) max_out = reads - hs_cnt;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic clear_stats();
    hs_cnt = 0; load_cnt = 0; done_cnt = 0; cen_cnt = 0; valid_cnt = 0;
    stall_model = 0; overlap_cnt = 0; reads = 0; max_out = 0;
    first_valid_cyc = -1; first_hs_cyc = -1; last_hs_cyc = -1;
    load_cyc = -1; done_cyc = -1;
    addr_log.delete();
  endtask

  task automatic start_job(input logic [ADDR_W-1:0] b, input logic [CNT_W-1:0] n);
    @(posedge CLK); #1;
    clear_stats();
    start = 1'b1; base_addr = b; num_rows = n;
    for (int i = 0; i < int'(n); i++) exp_q.push_back(pat(ADDR_W'(int'(b) + i)));
    @(posedge CLK); #1;
    start = 1'b0;
    t0 = cyc;
  endtask

  // Bounded wait for done; returns at the negedge where done is high, then
  // checks that busy drops on the following cycle.
  task automatic wait_done(input string name, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK);
      if (done) begin ok = 1'b1; break; end
    end
    check({name, "_done_seen"}, ok, 1);
    @(negedge CLK);
    check({name, "_busy_low"}, busy, 0);
    check({name, "_done_one_cycle"}, done, 0);
  endtask

  initial begin
    repeat (2) @(posedge CLK);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cen", buf_CEN, 1);
    check("rst_addr", buf_A, 0);
    check("rst_wvalid", w_valid, 0);
    check("rst_wdata", w_data, 0);
    check("rst_wload", w_load, 0);
    check("wen_const", buf_WEN, 1);
    check("retn_const", buf_RETN, 1);
`ifdef WL_STALL_CNT_EN
    check("rst_stall_cnt", stall_cnt, 0);
`endif
    @(negedge CLK);
    RSTN = 1'b1;

    // Full-rate 16-row job
    w_ready = 1'b1;
    start_job(13'd0, 5'd16);
    wait_done("full", 80);
    check("full_latency", first_valid_cyc - t0, 2);
    check("full_hs_cnt", hs_cnt, 16);
    check("full_back_to_back", last_hs_cyc - first_hs_cyc, 15);
    check("full_wload_cnt", load_cnt, 1);
    check("full_done_cnt", done_cnt, 1);
    check("full_done_after_load", done_cyc - load_cyc, 1);
    check("full_load_no_valid", overlap_cnt, 0);
    check("full_q_empty", exp_q.size(), 0);
    check("full_outstanding", max_out <= 2, 1);

    // Backpressure, 4 rows
    @(posedge CLK); #1;
    pidx = 0; pat_en = 1'b1;
    start_job(13'd40, 5'd4);
    wait_done("bp", 120);
    check("bp_hs_cnt", hs_cnt, 4);
    check("bp_q_empty", exp_q.size(), 0);
    check("bp_outstanding", max_out <= 2, 1);
    check("bp_wload_cnt", load_cnt, 1);
    check("bp_done_cnt", done_cnt, 1);
    check("bp_load_no_valid", overlap_cnt, 0);
`ifdef WL_STALL_CNT_EN
    check("bp_stall_cnt", stall_cnt, stall_model);
`endif
    pat_en = 1'b0;
    @(posedge CLK); #3;
    w_ready = 1'b1;

    // Zero rows
    start_job(13'd5, 5'd0);
    wait_done("zero", 10);
    check("zero_done_next_cycle", done_cyc - t0, 0);
    check("zero_no_read", cen_cnt, 0);
    check("zero_no_valid", valid_cnt, 0);
    check("zero_no_wload", load_cnt, 0);
    check("zero_done_cnt", done_cnt, 1);

    // Address wrap
    start_job(13'd8190, 5'd3);
    wait_done("wrap", 40);
    check("wrap_read_cnt", addr_log.size(), 3);
    if (addr_log.size() == 3) begin
      check("wrap_a0", addr_log[0], 13'd8190);
      check("wrap_a1", addr_log[1], 13'd8191);
      check("wrap_a2", addr_log[2], 13'd0);
    end
    check("wrap_q_empty", exp_q.size(), 0);

    // Start while busy is ignored
    start_job(13'd200, 5'd16);
    repeat (3) @(posedge CLK);
    #1;
    start = 1'b1; base_addr = 13'd300; num_rows = 5'd2;
    @(posedge CLK); #1;
    start = 1'b0;
    wait_done("busy_start", 80);
    repeat (10) @(negedge CLK);
    check("busy_start_done_cnt", done_cnt, 1);
    check("busy_start_hs_cnt", hs_cnt, 16);
    check("busy_start_reads", cen_cnt, 16);
    check("busy_start_q_empty", exp_q.size(), 0);

    // Reset mid-job after the 2nd handshake
    start_job(13'd0, 5'd16);
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
        @(posedge CLK); #1;
        if (hs_cnt >= 2) begin seen = 1'b1; break; end
      end
      check("midrst_two_beats", seen, 1);
    end
    RSTN = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_cen", buf_CEN, 1);
    check("midrst_addr", buf_A, 0);
    check("midrst_wvalid", w_valid, 0);
    check("midrst_wdata", w_data, 0);
    check("midrst_wload", w_load, 0);
`ifdef WL_STALL_CNT_EN
    check("midrst_stall_cnt", stall_cnt, 0);
`endif
    exp_q.delete();
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RSTN = 1'b1;
    repeat (3) @(negedge CLK);
    check("midrst_no_done", done_cnt, 0);
    check("midrst_idle_no_read", buf_CEN, 1);
    start_job(13'd50, 5'd4);
    wait_done("after_rst", 40);
    check("after_rst_hs_cnt", hs_cnt, 4);
    check("after_rst_done_cnt", done_cnt, 1);
    check("after_rst_wload_cnt", load_cnt, 1);
    check("after_rst_q_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
